// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : core_sequencer
//  Purpose  : Multi-cycle control FSM for a simple RISC core. It fetches, decodes
//             and executes each instruction and counts retired instructions.
//  Options  : define SEQ_MEM_WAIT_EN to honour mem_rbusy / mem_wbusy wait states.
//  Revision : 1.0  initial release
// ============================================================================
module core_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_system,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        mem_rstrb,
    output logic        mem_wstrb,
    output logic        addr_sel,
    output logic        instr_ld,
    output logic        regs_ld,
    output logic        pc_ld,
    output logic        wb_en,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH_INSTR = 3'd0,
        S_WAIT_INSTR  = 3'd1,
        S_FETCH_REGS  = 3'd2,
        S_EXECUTE     = 3'd3,
        S_LOAD        = 3'd4,
        S_WAIT_DATA   = 3'd5,
        S_STORE       = 3'd6,
        S_HALT        = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_store_done;
    logic [31:0] r_instret;

    logic        w_rbusy;
    logic        w_wbusy;
    logic        w_rstrb;
    logic        w_wstrb;
    logic        w_addr_sel;
    logic        w_instr_ld;
    logic        w_regs_ld;
    logic        w_pc_ld;
    logic        w_wb_en;
    logic        w_halt;
    logic        w_retire;

`ifdef SEQ_MEM_WAIT_EN
    assign w_rbusy = mem_rbusy;
    assign w_wbusy = mem_wbusy;
`else
    // Without wait-state support every memory access completes in one cycle.
    logic w_unused_busy;
    assign w_unused_busy = mem_rbusy ^ mem_wbusy;
    assign w_rbusy       = 1'b0;
    assign w_wbusy       = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_rstrb    = 1'b0;
        w_wstrb    = 1'b0;
        w_addr_sel = 1'b0;
        w_instr_ld = 1'b0;
        w_regs_ld  = 1'b0;
        w_pc_ld    = 1'b0;
        w_wb_en    = 1'b0;
        w_halt     = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH_INSTR: begin
                w_rstrb = 1'b1;
                w_next  = S_WAIT_INSTR;
            end
            S_WAIT_INSTR: begin
                if (!w_rbusy) begin
                    w_instr_ld = 1'b1;
                    w_next     = S_FETCH_REGS;
                end
            end
            S_FETCH_REGS: begin
                w_regs_ld = 1'b1;
                w_next    = S_EXECUTE;
            end
            S_EXECUTE: begin
                // SYSTEM wins over memory classes; load wins over store.
                if (is_system) begin
                    w_next = S_HALT;
                end else if (is_load) begin
                    w_pc_ld = 1'b1;
                    w_next  = S_LOAD;
                end else if (is_store) begin
                    w_pc_ld = 1'b1;
                    w_next  = S_STORE;
                end else begin
                    w_pc_ld  = 1'b1;
                    w_wb_en  = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH_INSTR;
                end
            end
            S_LOAD: begin
                w_rstrb    = 1'b1;
                w_addr_sel = 1'b1;
                w_next     = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                w_addr_sel = 1'b1;
                if (!w_rbusy) begin
                    w_wb_en  = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH_INSTR;
                end
            end
            S_STORE: begin
                w_addr_sel = 1'b1;
                // Strobe once on entry; busy is only meaningful after the strobe.
                if (!r_store_done) begin
                    w_wstrb = 1'b1;
                end else if (!w_wbusy) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH_INSTR;
                end
            end
            S_HALT: begin
                w_halt = 1'b1;
            end
            default: begin
                w_next = S_FETCH_INSTR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH_INSTR;
            r_instret    <= 32'd0;
            r_store_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_instret    <= r_instret + {31'd0, w_retire};
            r_store_done <= (r_state == S_STORE) && (w_next == S_STORE);
        end
    end

    assign mem_rstrb = w_rstrb    & ~reset;
    assign mem_wstrb = w_wstrb    & ~reset;
    assign instr_ld  = w_instr_ld & ~reset;
    assign regs_ld   = w_regs_ld  & ~reset;
    assign pc_ld     = w_pc_ld    & ~reset;
    assign wb_en     = w_wb_en    & ~reset;
    assign halted    = w_halt     & ~reset;
    assign addr_sel  = w_addr_sel;
    assign state     = r_state;
    assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_sequencer
//  Purpose  : Scoreboard bench for core_sequencer: expected pulse records are
//             queued per instruction and popped by a monitor on every pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_sequencer;

`ifdef SEQ_MEM_WAIT_EN
    localparam int WAIT_EN = 1;
`else
    localparam int WAIT_EN = 0;
`endif

    localparam logic [5:0] P_RSTRB = 6'b100000;
    localparam logic [5:0] P_WSTRB = 6'b010000;
    localparam logic [5:0] P_ILD   = 6'b001000;
    localparam logic [5:0] P_RLD   = 6'b000100;
    localparam logic [5:0] P_PC    = 6'b000010;
    localparam logic [5:0] P_WB    = 6'b000001;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_SYS = 3, K_LDST = 4, K_SYSLD = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_load = 1'b0, is_store = 1'b0, is_system = 1'b0;
    logic        mem_rbusy = 1'b0, mem_wbusy = 1'b0;
    logic        mem_rstrb, mem_wstrb, addr_sel, instr_ld, regs_ld, pc_ld, wb_en, halted;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [5:0]  w_pulses;

    core_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_system (is_system),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .mem_rstrb (mem_rstrb),
        .mem_wstrb (mem_wstrb),
        .addr_sel  (addr_sel),
        .instr_ld  (instr_ld),
        .regs_ld   (regs_ld),
        .pc_ld     (pc_ld),
        .wb_en     (wb_en),
        .halted    (halted),
        .state     (state),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    assign w_pulses = {mem_rstrb, mem_wstrb, instr_ld, regs_ld, pc_ld, wb_en};

    typedef struct packed {
        logic [5:0]  p;
        logic        a;
        logic [2:0]  s;
        logic [31:0] ir;
    } rec_t;

    rec_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ir = 32'd0;

    function automatic rec_t mk(input logic [5:0] p, input logic a, input logic [2:0] s,
                                input logic [31:0] ir);
        rec_t r;
        r.p = p; r.a = a; r.s = s; r.ir = ir;
        return r;
    endfunction

    // Monitor: every cycle with any pulse must match the next queued record.
    always @(negedge clk) begin
        rec_t e;
        if (w_pulses != 6'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got pulses=%b state=%0d, expected no pulse",
                         w_pulses, state);
            end else begin
                e = exp_q.pop_front();
                if ({w_pulses, addr_sel, state, instret} != e) begin
                    errors++;
                    $display("FAIL pulse_seq: got p=%b a=%b s=%0d ir=%h, expected p=%b a=%b s=%0d ir=%h",
                             w_pulses, addr_sel, state, instret, e.p, e.a, e.s, e.ir);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] ir);
        exp_q.push_back(mk(P_RSTRB, 1'b0, 3'd0, ir));
        exp_q.push_back(mk(P_ILD,   1'b0, 3'd1, ir));
        exp_q.push_back(mk(P_RLD,   1'b0, 3'd2, ir));
    endtask

    // Runs one instruction starting in FETCH_INSTR and checks its duration.
    task automatic run_instr(input int kind, input int rbusy_n, input int wbusy_n,
                             input logic rbusy_all, input int exp_cycles,
                             input int exp_store_cyc, input string nm);
        int cnt = 0;
        int sc  = 0;
        int rb  = rbusy_n;
        logic retire;
        is_load   = (kind == K_LOAD) || (kind == K_LDST) || (kind == K_SYSLD);
        is_store  = (kind == K_STORE) || (kind == K_LDST);
        is_system = (kind == K_SYS) || (kind == K_SYSLD);
        retire    = !is_system;
        push_fetch(exp_ir);
        if (kind == K_ALU) begin
            exp_q.push_back(mk(P_PC | P_WB, 1'b0, 3'd3, exp_ir));
        end else if (kind == K_LOAD || kind == K_LDST) begin
            exp_q.push_back(mk(P_PC,    1'b0, 3'd3, exp_ir));
            exp_q.push_back(mk(P_RSTRB, 1'b1, 3'd4, exp_ir));
            exp_q.push_back(mk(P_WB,    1'b1, 3'd5, exp_ir));
        end else if (kind == K_STORE) begin
            exp_q.push_back(mk(P_PC,    1'b0, 3'd3, exp_ir));
            exp_q.push_back(mk(P_WSTRB, 1'b1, 3'd6, exp_ir));
        end
        mem_rbusy = rbusy_all;
        mem_wbusy = 1'b0;
        do begin
            tick();
            cnt++;
            if (state == 3'd6) sc++;
            mem_rbusy = rbusy_all || (state == 3'd5 && rb > 0);
            if (state == 3'd5 && rb > 0) rb--;
            mem_wbusy = (state == 3'd6) && (sc >= 2) && (sc <= 1 + wbusy_n);
        end while (state != 3'd0 && state != 3'd7 && cnt < 60);
        is_load = 1'b0; is_store = 1'b0; is_system = 1'b0;
        mem_rbusy = 1'b0; mem_wbusy = 1'b0;
        if (retire) exp_ir = exp_ir + 32'd1;
        chk({nm, "_cycles"}, cnt, exp_cycles);
        chk({nm, "_state"}, {29'd0, state}, retire ? 32'd0 : 32'd7);
        chk({nm, "_instret"}, instret, exp_ir);
        if (exp_store_cyc > 0) chk({nm, "_store_cycles"}, sc, exp_store_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // Reset state
        repeat (3) tick();
        chk("reset_pulses", {24'd0, w_pulses, halted, 1'b0}, 32'd0);
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        reset = 1'b0;

        // Three back-to-back ALU instructions
        run_instr(K_ALU, 0, 0, 1'b0, 4, 0, "alu0");
        run_instr(K_ALU, 0, 0, 1'b0, 4, 0, "alu1");
        run_instr(K_ALU, 0, 0, 1'b0, 4, 0, "alu2");
        chk("alu_instret_3", instret, 32'd3);

        // Loads and stores, with and without busy
        run_instr(K_LOAD,  0, 0, 1'b0, 6, 0, "load");
        run_instr(K_LOAD,  3, 0, 1'b0, (WAIT_EN != 0) ? 9 : 6, 0, "load_busy");
        run_instr(K_STORE, 0, 2, 1'b0, (WAIT_EN != 0) ? 8 : 6, (WAIT_EN != 0) ? 4 : 2, "store_busy");
        run_instr(K_STORE, 0, 0, 1'b0, 6, 2, "store");
        run_instr(K_LDST,  0, 0, 1'b0, 6, 0, "ldst_as_load");
`ifndef SEQ_MEM_WAIT_EN
        run_instr(K_LOAD,  0, 0, 1'b1, 6, 0, "load_rbusy_tied");
`endif

        // instret wrap via preload
        exp_ir = 32'hFFFF_FFFF;
        force dut.r_instret = 32'hFFFF_FFFF;
        push_fetch(exp_ir);
        exp_q.push_back(mk(P_PC | P_WB, 1'b0, 3'd3, exp_ir));
        tick();
        release dut.r_instret;
        #1;
        chk("preload_hold", instret, 32'hFFFF_FFFF);
        repeat (3) tick();
        chk("wrap_state", {29'd0, state}, 32'd0);
        chk("wrap_instret", instret, 32'd0);
        exp_ir = 32'd0;

        // Reset in the middle of WAIT_DATA
        is_load = 1'b1;
        push_fetch(exp_ir);
        exp_q.push_back(mk(P_PC,    1'b0, 3'd3, exp_ir));
        exp_q.push_back(mk(P_RSTRB, 1'b1, 3'd4, exp_ir));
        for (int i = 0; i < 10 && state != 3'd5; i++) tick();
        chk("reach_wait_data", {29'd0, state}, 32'd5);
        reset = 1'b1;
        #1;
        chk("reset_wait_pulses", {26'd0, w_pulses}, 32'd0);
        tick();
        is_load = 1'b0;
        chk("reset_wait_state", {29'd0, state}, 32'd0);
        chk("reset_wait_instret", instret, 32'd0);
        reset = 1'b0;
        exp_ir = 32'd0;
        run_instr(K_ALU, 0, 0, 1'b0, 4, 0, "alu_after_reset");

        // SYSTEM halts and holds
        run_instr(K_SYS, 0, 0, 1'b0, 4, 0, "system");
        bad = 0;
        repeat (100) begin
            tick();
            if (state != 3'd7 || !halted || w_pulses != 6'd0) bad++;
        end
        chk("halt_hold_bad_cycles", bad, 0);
        chk("halted_flag", {31'd0, halted}, 32'd1);
        reset = 1'b1;
        #1;
        chk("halt_reset_outputs", {25'd0, w_pulses, halted}, 32'd0);
        tick();
        chk("halt_reset_state", {29'd0, state}, 32'd0);
        chk("halt_reset_instret", instret, 32'd0);
        reset = 1'b0;
        exp_ir = 32'd0;

        // SYSTEM has priority over load
        run_instr(K_SYSLD, 0, 0, 1'b0, 4, 0, "sys_over_load");
        reset = 1'b1;
        tick();
        chk("final_reset_state", {29'd0, state}, 32'd0);

        repeat (3) tick();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports is_load, is_store and is_system, inputs, 1 bit each: decoded class of the currently latched instruction, valid from FETCH_REGS onward.
REQ-004 SHALL have ports mem_rbusy and mem_wbusy, inputs, 1 bit each: memory read or write still in progress.
REQ-005 SHALL have port mem_rstrb, output, 1 bit: one-cycle memory read request.
REQ-006 SHALL have port mem_wstrb, output, 1 bit: one-cycle memory write request.
REQ-007 SHALL have port addr_sel, output, 1 bit: memory address source; 0 = PC, 1 = load/store address.
REQ-008 SHALL have ports instr_ld, regs_ld, pc_ld and wb_en, outputs, 1 bit each: load-enable pulses to the datapath for instruction latch, src1/src2 register read, PC update and register writeback.
REQ-009 SHALL have port halted, output, 1 bit: core stopped by a SYSTEM instruction.
REQ-010 SHALL have port state, output, 3 bits: current FSM state code.
REQ-011 SHALL have port instret, output, 32 bits: retired-instruction counter.

Function
REQ-012 SHALL implement state codes FETCH_INSTR=0, WAIT_INSTR=1, FETCH_REGS=2, EXECUTE=3, LOAD=4, WAIT_DATA=5, STORE=6, HALT=7.
REQ-013 SHALL decode all outputs except instret combinationally from state, plus mem_wbusy, mem_rbusy, the class inputs and the store flag; every pulse output SHALL be 0 in any cycle where reset=1.
REQ-014 FETCH_INSTR SHALL assert mem_rstrb with addr_sel=0 and go to WAIT_INSTR.
REQ-015 WAIT_INSTR SHALL do the following while mem_rbusy=0: assert instr_ld and go to FETCH_REGS; while mem_rbusy=1 it SHALL hold state with no pulses.
REQ-016 FETCH_REGS SHALL assert regs_ld and go to EXECUTE.
REQ-017 EXECUTE SHALL select its action by priority is_system, then is_load, then is_store, then ALU (neither).
- is_system: go to HALT; no pc_ld, no wb_en.
- is_load: assert pc_ld; go to LOAD.
- is_store: assert pc_ld; go to STORE.
- ALU: assert pc_ld and wb_en; go to FETCH_INSTR.
REQ-018 LOAD SHALL assert mem_rstrb with addr_sel=1 and go to WAIT_DATA.
REQ-019 WAIT_DATA SHALL keep addr_sel=1 and do the following while mem_rbusy=0: assert wb_en and go to FETCH_INSTR; otherwise it SHALL hold.
REQ-020 STORE SHALL keep addr_sel=1 and handle the write as follows.
- Assert mem_wstrb only in the first cycle in STORE, tracked by an internal one-bit flag cleared on exit.
- From the cycle after the strobe, go to FETCH_INSTR once mem_wbusy=0.
REQ-021 HALT SHALL assert halted, emit no pulses and remain in HALT until reset.
REQ-022 instret SHALL increment by 1 on each retirement: the EXECUTE->FETCH_INSTR, WAIT_DATA->FETCH_INSTR and STORE->FETCH_INSTR transitions.
REQ-023 instret SHALL wrap from 32'hFFFFFFFF to 0 with no flag; SYSTEM instructions SHALL NOT be counted.
REQ-024 The only illegal class input is is_load and is_store both high; it SHALL resolve to load by the priority in REQ-017.
REQ-025 Cycle counts without busy stalls SHALL be: ALU = 4 cycles, load = 6, store = 6 (STORE lasts 2 cycles), SYSTEM reaches HALT after 4 cycles.

Reset
REQ-026 On a clock edge with reset=1, state SHALL become FETCH_INSTR, instret SHALL become 0 and the store flag SHALL clear, from any state including mid-wait and HALT.
REQ-027 While reset=1, halted=0 and all pulses SHALL be 0; the first mem_rstrb SHALL occur in the first cycle after reset deasserts.

Configuration
REQ-028 Macro SEQ_MEM_WAIT_EN SHALL select memory wait-state support.
- Defined: mem_rbusy and mem_wbusy SHALL be honoured as in REQ-015, REQ-019 and REQ-020.
- Undefined: both ports SHALL remain present but be ignored; WAIT_INSTR and WAIT_DATA SHALL last exactly 1 cycle and STORE exactly 2 cycles.

Verification
REQ-029 Reset, then is_* = 0 with busy signals 0 -> pulse sequence mem_rstrb, instr_ld, regs_ld, pc_ld+wb_en repeating every 4 cycles; instret = 3 after 12 cycles.
REQ-030 Load with mem_rbusy=1 for 3 cycles in WAIT_DATA (SEQ_MEM_WAIT_EN defined) -> wb_en delayed 3 cycles; load takes 9 cycles; instret +1.
REQ-031 Store with mem_wbusy=1 for 2 cycles -> exactly one mem_wstrb with addr_sel=1; FETCH_INSTR entered 4 cycles after entering STORE.
REQ-032 is_system in EXECUTE -> state=7 and halted=1 held for 100 cycles with no pulses; reset -> state=0 and halted=0.
REQ-033 instret preloaded to 32'hFFFFFFFF (force), then one ALU instruction -> instret=0; reset asserted in WAIT_DATA -> state=0 and instret=0 next cycle.
REQ-034 SEQ_MEM_WAIT_EN undefined, mem_rbusy tied to 1 -> load still completes in 6 cycles.
